tdc7200_ctrl: RTL and testbench
===============================

TDC7200_CTRL -- requirements
Module: tdc7200_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65535, sets the clk cycles allowed between the measurement-start write and INTB assertion.
REQ-002 Parameter CFG1_MODE, default 8'h00, sets CONFIG1 bits [7:1]; bit 0 is always forced to 1 (START_MEAS).
REQ-003 Parameter CFG2_VAL, default 8'h40, is the value written to CONFIG2.
REQ-004 Port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port meas_start, input, 1 bit: single-cycle measurement request.
REQ-007 Port busy, output, 1 bit: a measurement sequence is in progress.
REQ-008 Port result_valid, output, 1 bit: single-cycle pulse when all result registers are updated.
REQ-009 Port timeout_err, output, 1 bit: single-cycle pulse when INTB wait expires.
REQ-010 Ports time1, cal1, cal2, clock_count1, output, 24 bits each: captured TDC register values.
REQ-011 Port intb_n, input, 1 bit: TDC7200 interrupt, asynchronous, active-low.
REQ-012 Ports spi_start (out, 1), spi_tx (out, 16), spi_rx (in, 32), spi_busy (in, 1): drive a spi_master instance built with TX_WIDTH=16, RX_WIDTH=32.

Function
REQ-013 Each SPI operation: assert spi_start for exactly 1 cycle with spi_tx stable; wait for spi_busy to rise, then fall; then the operation is complete.
REQ-014 spi_tx = {cmd, data}, with cmd = {1'b0 (no auto-increment), rw, addr[5:0]}; rw=1 means write. For reads, data = 8'h00 and the result is taken from spi_rx[23:0].
REQ-015 States: IDLE, WR_CFG2, WR_CFG1, WAIT_INT, RD_TIME1, RD_CAL1, RD_CAL2, RD_CCNT, DONE. Each WR_/RD_ state contains ISSUE and WAIT substates.
REQ-016 IDLE->WR_CFG2 on meas_start. WR_CFG2 writes addr 0x01. WR_CFG1 writes addr 0x00 with {CFG1_MODE[7:1],1'b1}.
REQ-017 WAIT_INT: a counter is cleared on entry. Leave to RD_TIME1 when synchronized intb_n is 0. Otherwise, when the counter reaches TIMEOUT_CYCLES, pulse timeout_err and go to IDLE; no result registers change.
REQ-018 Reads: RD_TIME1 uses addr 0x10 and captures time1; RD_CAL1 uses 0x1B and captures cal1; RD_CAL2 uses 0x1C and captures cal2. The next state after RD_CAL2 is per REQ-024.
REQ-019 DONE lasts 1 cycle, pulses result_valid, then returns to IDLE.
REQ-020 busy = (state != IDLE). meas_start is ignored while busy.
REQ-021 intb_n passes through a 2-flop synchronizer before use. Minimum latency from intb_n falling to spi_start is 3 cycles.
REQ-022 intb_n asserted before WAIT_INT is entered is accepted at WAIT_INT entry.

Reset
REQ-023 On rst_n low, at any point including mid-transfer:
- state = IDLE; busy, spi_start, result_valid, timeout_err = 0
- spi_tx = 0; time1, cal1, cal2, clock_count1 = 0; synchronizer flops = 1
- no SPI operation resumes after reset release.

Configuration
REQ-024 Macro TDC_CLKCNT_EN:
- Defined: RD_CAL2 -> RD_CCNT, which reads addr 0x11 into clock_count1, then -> DONE.
- Undefined: RD_CAL2 -> DONE, RD_CCNT is absent, and clock_count1 is held at 0.

Structure
REQ-025 Package tdc7200_pkg holds:
- register address localparams (0x00, 0x01, 0x10, 0x11, 0x1B, 0x1C)
- command bit positions
- the state enum typedef.
REQ-026 One sub-module, sync_2ff, is instantiated for intb_n; all other logic is inline.

Verification
REQ-027 meas_start pulse, SPI slave model asserts intb_n 100 cycles after the CONFIG1 write, with TIME1=24'h000123, CAL1=24'h000456, CAL2=24'h001234 -> SPI frames 16'h4140, 16'h4001, 16'h1000, 16'h1B00, 16'h1C00 in order; result_valid pulses once; outputs match.
REQ-028 intb_n never asserted, TIMEOUT_CYCLES=50 -> timeout_err pulses exactly 50 cycles after WAIT_INT entry; no read frames issued; busy falls the next cycle.
REQ-029 meas_start re-pulsed during RD_CAL1 -> ignored; exactly one result_valid, exactly 5 frames.
REQ-030 rst_n low during the RD_TIME1 transfer -> all outputs 0 the next cycle; no spi_start after release until a new meas_start.
REQ-031 TDC_CLKCNT_EN defined, CLOCK_COUNT1=24'h00ABCD -> 6th frame 16'h1100; clock_count1=24'h00ABCD at result_valid.
REQ-032 intb_n held low before meas_start -> no wait in WAIT_INT; RD_TIME1 frame follows the CONFIG1 frame within 3 cycles of spi_busy falling.

Source files
------------

// File: rtl/tdc7200_pkg.sv
// Shared definitions for the TDC7200 measurement controller: register map,
// SPI command layout and FSM state types. Honours macro TDC_CLKCNT_EN.
package tdc7200_pkg;

  localparam logic [5:0] ADDR_CONFIG1       = 6'h00;
  localparam logic [5:0] ADDR_CONFIG2       = 6'h01;
  localparam logic [5:0] ADDR_TIME1         = 6'h10;
  localparam logic [5:0] ADDR_CLOCK_COUNT1  = 6'h11;
  localparam logic [5:0] ADDR_CALIBRATION1  = 6'h1B;
  localparam logic [5:0] ADDR_CALIBRATION2  = 6'h1C;

  localparam int CMD_AI_BIT   = 15;
  localparam int CMD_RW_BIT   = 14;
  localparam int CMD_ADDR_LSB = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_CFG2,
    ST_WR_CFG1,
    ST_WAIT_INT,
    ST_RD_TIME1,
    ST_RD_CAL1,
    ST_RD_CAL2,
`ifdef TDC_CLKCNT_EN
    ST_RD_CCNT,
`endif
    ST_DONE
  } state_e;

  typedef enum logic {
    SUB_ISSUE,
    SUB_WAIT
  } sub_e;

  // Single-register access frame; auto-increment is never used.
  function automatic logic [15:0] spi_frame(input logic       rw,
                                            input logic [5:0] addr,
                                            input logic [7:0] data);
    logic [15:0] f;
    f                         = '0;
    f[CMD_AI_BIT]             = 1'b0;
    f[CMD_RW_BIT]             = rw;
    f[CMD_ADDR_LSB +: 6]      = addr;
    f[7:0]                    = data;
    return f;
  endfunction

endpackage

// File: rtl/tdc7200_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input; both flops
// reset to RST_VAL so an idle-high line stays high through reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: non-blocking assignments keep the two flops a true shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/tdc7200_ctrl.sv
// TDC7200 measurement sequencer driving a 16-bit-TX / 32-bit-RX SPI master.
// Macro TDC_CLKCNT_EN adds the CLOCK_COUNT1 read after CALIBRATION2.
module tdc7200_ctrl
  import tdc7200_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  CFG1_MODE      = 8'h00,
  parameter logic [7:0]  CFG2_VAL       = 8'h40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meas_start,
  output logic        busy,
  output logic        result_valid,
  output logic        timeout_err,
  output logic [23:0] time1,
  output logic [23:0] cal1,
  output logic [23:0] cal2,
  output logic [23:0] clock_count1,
  input  logic        intb_n,
  output logic        spi_start,
  output logic [15:0] spi_tx,
  input  logic [31:0] spi_rx,
  input  logic        spi_busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_e             r_state, w_state_nxt, w_op_nxt;
  sub_e               r_sub, w_sub_nxt;
  logic               r_seen, w_seen_nxt;
  logic               w_is_op, w_op_done, w_intb_sync;
  logic [CNT_W-1:0]   r_cnt;
  logic [23:0]        r_time1, r_cal1, r_cal2;
  // Only the low 24 bits of a read frame carry register data.
  logic               w_unused_rx;

  assign w_unused_rx = ^spi_rx[31:24];

  sync_2ff #(.RST_VAL(1'b1)) u_intb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (intb_n),
    .o_q   (w_intb_sync)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_state;
    w_sub_nxt    = r_sub;
    w_seen_nxt   = r_seen;
    w_is_op      = 1'b0;
    w_op_done    = 1'b0;
    spi_start    = 1'b0;
    spi_tx       = '0;
    timeout_err  = 1'b0;
    result_valid = 1'b0;

    case (r_state)
      ST_IDLE:     if (meas_start) w_state_nxt = ST_WR_CFG2;
      ST_WR_CFG2:  begin w_is_op = 1'b1; w_op_nxt = ST_WR_CFG1;
                         spi_tx = spi_frame(1'b1, ADDR_CONFIG2, CFG2_VAL); end
      ST_WR_CFG1:  begin w_is_op = 1'b1; w_op_nxt = ST_WAIT_INT;
                         spi_tx = spi_frame(1'b1, ADDR_CONFIG1, {CFG1_MODE[7:1], 1'b1}); end
      ST_WAIT_INT: begin
        if (!w_intb_sync) begin
          w_state_nxt = ST_RD_TIME1;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
          timeout_err = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_TIME1: begin w_is_op = 1'b1; w_op_nxt = ST_RD_CAL1;
                         spi_tx = spi_frame(1'b0, ADDR_TIME1, 8'h00); end
      ST_RD_CAL1:  begin w_is_op = 1'b1; w_op_nxt = ST_RD_CAL2;
                         spi_tx = spi_frame(1'b0, ADDR_CALIBRATION1, 8'h00); end
`ifdef TDC_CLKCNT_EN
      ST_RD_CAL2:  begin w_is_op = 1'b1; w_op_nxt = ST_RD_CCNT;
                         spi_tx = spi_frame(1'b0, ADDR_CALIBRATION2, 8'h00); end
      ST_RD_CCNT:  begin w_is_op = 1'b1; w_op_nxt = ST_DONE;
                         spi_tx = spi_frame(1'b0, ADDR_CLOCK_COUNT1, 8'h00); end
`else
      ST_RD_CAL2:  begin w_is_op = 1'b1; w_op_nxt = ST_DONE;
                         spi_tx = spi_frame(1'b0, ADDR_CALIBRATION2, 8'h00); end
`endif
      ST_DONE:     begin result_valid = 1'b1; w_state_nxt = ST_IDLE; end
      default:     w_state_nxt = ST_IDLE;
    endcase

    // Shared SPI handshake: one start cycle, then busy must rise and fall.
    if (w_is_op) begin
      if (r_sub == SUB_ISSUE) begin
        spi_start  = 1'b1;
        w_sub_nxt  = SUB_WAIT;
        w_seen_nxt = 1'b0;
      end else if (spi_busy) begin
        w_seen_nxt = 1'b1;
      end else if (r_seen) begin
        w_op_done   = 1'b1;
        w_sub_nxt   = SUB_ISSUE;
        w_state_nxt = w_op_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sub   <= SUB_ISSUE;
      r_seen  <= 1'b0;
      r_cnt   <= '0;
      r_time1 <= '0;
      r_cal1  <= '0;
      r_cal2  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sub   <= w_sub_nxt;
      r_seen  <= w_seen_nxt;
      r_cnt   <= (r_state == ST_WAIT_INT) ? r_cnt + 1'b1 : '0;
      if (w_op_done) begin
        case (r_state)
          ST_RD_TIME1: r_time1 <= spi_rx[23:0];
          ST_RD_CAL1:  r_cal1  <= spi_rx[23:0];
          ST_RD_CAL2:  r_cal2  <= spi_rx[23:0];
          default:     ;
        endcase
      end
    end
  end

`ifdef TDC_CLKCNT_EN
  logic [23:0] r_ccnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_ccnt <= '0;
    else if (w_op_done && r_state == ST_RD_CCNT) r_ccnt <= spi_rx[23:0];
  end

  assign clock_count1 = r_ccnt;
`else
  assign clock_count1 = '0;
`endif

  assign busy  = (r_state != ST_IDLE);
  assign time1 = r_time1;
  assign cal1  = r_cal1;
  assign cal2  = r_cal2;

endmodule

// File: tb/tb_tdc7200_ctrl.sv
// Randomized bench for tdc7200_ctrl: an SPI-master/TDC7200 model answers reads,
// and every measurement is compared against the expected frame list and results.
module tb_tdc7200_ctrl;

  localparam int T_OUT = 120;

  logic        clk = 1'b0;
  logic        rst_n, meas_start, busy, result_valid, timeout_err;
  logic        intb_n, spi_start, spi_busy;
  logic [23:0] time1, cal1, cal2, clock_count1;
  logic [15:0] spi_tx;
  logic [31:0] spi_rx;

  always #5 clk = ~clk;

  tdc7200_ctrl #(
    .TIMEOUT_CYCLES (T_OUT),
    .CFG1_MODE      (8'h00),
    .CFG2_VAL       (8'h40)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .meas_start   (meas_start),
    .busy         (busy),
    .result_valid (result_valid),
    .timeout_err  (timeout_err),
    .time1        (time1),
    .cal1         (cal1),
    .cal2         (cal2),
    .clock_count1 (clock_count1),
    .intb_n       (intb_n),
    .spi_start    (spi_start),
    .spi_tx       (spi_tx),
    .spi_rx       (spi_rx),
    .spi_busy     (spi_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // TDC register contents and interrupt behaviour of the device model.
  logic [23:0] m_time1, m_cal1, m_cal2, m_ccnt;
  int          m_intb_delay = -1;
  logic        intb_force   = 1'b0;
  logic        intb_model;

  assign intb_n = intb_model & ~intb_force;

  function automatic logic [23:0] rd_val(input logic [5:0] addr);
    case (addr)
      6'h10:   return m_time1;
      6'h1B:   return m_cal1;
      6'h1C:   return m_cal2;
      6'h11:   return m_ccnt;
      default: return 24'h5A5A5A;
    endcase
  endfunction

  // SPI master + TDC model: busy rises after 0..2 cycles, lasts 2..7 cycles.
  logic        sl_act;
  int          sl_pre, sl_len, intb_cnt;
  logic [15:0] sl_frame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_busy   <= 1'b0;
      spi_rx     <= '0;
      sl_act     <= 1'b0;
      sl_pre     <= 0;
      sl_len     <= 0;
      sl_frame   <= '0;
      intb_model <= 1'b1;
      intb_cnt   <= -1;
    end else begin
      if (intb_cnt > 0) intb_cnt <= intb_cnt - 1;
      else if (intb_cnt == 0) begin
        intb_model <= 1'b0;
        intb_cnt   <= -1;
      end
      if (spi_start && !sl_act) begin
        sl_act   <= 1'b1;
        sl_frame <= spi_tx;
        sl_pre   <= $urandom_range(0, 2);
        sl_len   <= $urandom_range(1, 6);
        if (spi_tx == 16'h4001) intb_model <= 1'b1;
      end else if (sl_act) begin
        if (sl_pre > 0) sl_pre <= sl_pre - 1;
        else if (!spi_busy) begin
          spi_busy <= 1'b1;
          spi_rx   <= {8'($urandom), rd_val(sl_frame[13:8])};
        end else if (sl_len > 0) sl_len <= sl_len - 1;
        else begin
          spi_busy <= 1'b0;
          sl_act   <= 1'b0;
          if (sl_frame == 16'h4001 && m_intb_delay >= 0) intb_cnt <= m_intb_delay;
        end
      end
    end
  end

  // Observation, sampled on the falling edge.
  int          cyc = 0;
  logic [15:0] frames[$];
  int          start_cyc[$];
  int          rv_count = 0, to_count = 0, to_cyc = 0, cfg1_fall = 0;
  logic [23:0] rv_t1, rv_c1, rv_c2, rv_cc;
  logic        prev_sb = 1'b0, prev_to = 1'b0, busy_after_to = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_sb <= spi_busy;
    prev_to <= timeout_err;
    if (rst_n) begin
      if (spi_start) begin
        frames.push_back(spi_tx);
        start_cyc.push_back(cyc);
      end
      if (prev_sb && !spi_busy && frames.size() > 0 && frames[frames.size()-1] == 16'h4001)
        cfg1_fall <= cyc;
      if (result_valid) begin
        rv_count <= rv_count + 1;
        rv_t1    <= time1;
        rv_c1    <= cal1;
        rv_c2    <= cal2;
        rv_cc    <= clock_count1;
      end
      if (timeout_err) begin
        to_count <= to_count + 1;
        to_cyc   <= cyc;
      end
      if (prev_to) busy_after_to <= busy;
    end
  end

  int base_fr, base_rv, base_to;

  function automatic logic [15:0] frame(input bit rw, input logic [5:0] addr, input logic [7:0] data);
    return {1'b0, rw, addr, data};
  endfunction

  task automatic start_meas(input int d, input logic [23:0] t1, c1, c2, cc);
    m_intb_delay = d;
    m_time1 = t1; m_cal1 = c1; m_cal2 = c2; m_ccnt = cc;
    base_fr = frames.size(); base_rv = rv_count; base_to = to_count;
    @(negedge clk); meas_start = 1'b1;
    @(negedge clk); meas_start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while ((rv_count + to_count == base_rv + base_to) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, 32'(n < 4000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_frame(input string tag, input logic [15:0] f);
    int n = 0;
    while (!(frames.size() > base_fr && frames[frames.size()-1] == f) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_frame_seen"}, 32'(n < 2000), 32'd1);
  endtask

  task automatic check_meas(input string tag);
    logic [15:0] exp_fr[$];
    logic [23:0] exp_cc;
    exp_fr = '{frame(1, 6'h01, 8'h40), frame(1, 6'h00, 8'h01), frame(0, 6'h10, 8'h00),
               frame(0, 6'h1B, 8'h00), frame(0, 6'h1C, 8'h00)};
`ifdef TDC_CLKCNT_EN
    exp_fr.push_back(frame(0, 6'h11, 8'h00));
    exp_cc = m_ccnt;
`else
    exp_cc = 24'h0;
`endif
    check({tag, "_nframes"}, 32'(frames.size() - base_fr), 32'(exp_fr.size()));
    for (int i = 0; i < exp_fr.size(); i++)
      if (base_fr + i < frames.size())
        check($sformatf("%s_frame%0d", tag, i), 32'(frames[base_fr+i]), 32'(exp_fr[i]));
    check({tag, "_nvalid"},   32'(rv_count - base_rv), 32'd1);
    check({tag, "_ntimeout"}, 32'(to_count - base_to), 32'd0);
    check({tag, "_time1"},    32'(rv_t1), 32'(m_time1));
    check({tag, "_cal1"},     32'(rv_c1), 32'(m_cal1));
    check({tag, "_cal2"},     32'(rv_c2), 32'(m_cal2));
    check({tag, "_ccnt"},     32'(rv_cc), 32'(exp_cc));
    check({tag, "_busy_end"}, 32'(busy),  32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy),         32'd0);
    check({tag, "_start"}, 32'(spi_start),    32'd0);
    check({tag, "_tx"},    32'(spi_tx),       32'd0);
    check({tag, "_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_tout"},  32'(timeout_err),  32'd0);
    check({tag, "_time1"}, 32'(time1),        32'd0);
    check({tag, "_cal1"},  32'(cal1),         32'd0);
    check({tag, "_cal2"},  32'(cal2),         32'd0);
    check({tag, "_ccnt"},  32'(clock_count1), 32'd0);
  endtask

  initial begin
    logic [23:0] prev_t1;
    rst_n      = 1'b0;
    meas_start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start_meas(100, 24'h000123, 24'h000456, 24'h001234, 24'h00ABCD);
    wait_end("dir");
    check_meas("dir");

    for (int i = 0; i < 8; i++) begin
      start_meas($urandom_range(0, 100), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
      wait_end($sformatf("rnd%0d", i));
      check_meas($sformatf("rnd%0d", i));
    end

    // INTB never asserts: timeout counted from WAIT_INT entry, results untouched.
    prev_t1 = m_time1;
    start_meas(-1, 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
    wait_end("tout");
    check("tout_nframes", 32'(frames.size() - base_fr), 32'd2);
    check("tout_npulse",  32'(to_count - base_to), 32'd1);
    check("tout_nvalid",  32'(rv_count - base_rv), 32'd0);
    check("tout_latency", 32'(to_cyc - (cfg1_fall + 1)), 32'(T_OUT));
    check("tout_busy_next", 32'(busy_after_to), 32'd0);
    check("tout_time1_kept", 32'(time1), 32'(prev_t1));

    // Second request while reading CALIBRATION1 must be ignored.
    start_meas(20, 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
    wait_frame("repulse", 16'h1B00);
    @(negedge clk); meas_start = 1'b1;
    @(negedge clk); meas_start = 1'b0;
    wait_end("repulse");
    repeat (30) @(negedge clk);
    check_meas("repulse");

    // INTB already low before the request: no wait in WAIT_INT.
    intb_force = 1'b1;
    repeat (5) @(negedge clk);
    start_meas(-1, 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
    wait_end("early");
    check_meas("early");
    if (frames.size() > base_fr + 2)
      check("early_gap_le3", 32'((start_cyc[base_fr+2] - cfg1_fall) <= 3), 32'd1);
    intb_force = 1'b0;

    // Reset in the middle of the TIME1 read.
    start_meas(10, 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
    wait_frame("midrst", 16'h1000);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midrst");
    @(negedge clk); rst_n = 1'b1;
    base_fr = frames.size();
    repeat (60) @(negedge clk);
    check("midrst_no_resume", 32'(frames.size() - base_fr), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    start_meas(40, 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
    wait_end("post_rst");
    check_meas("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
